// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - pipeline memory-access stage: alignment check, bus handshake, load extraction
module mem_lsu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid_i,
    input  logic            mem_load_i,
    input  logic            mem_store_i,
    input  logic [2:0]      mem_funct3_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic [XLEN-1:0] mem_wdata_i,
    input  logic            flush_i,
    output logic            bus_req_valid_o,
    input  logic            bus_req_ready_i,
    output logic            bus_req_we_o,
    output logic [XLEN-1:0] bus_req_addr_o,
    output logic [XLEN-1:0] bus_req_wdata_o,
    output logic [7:0]      bus_req_wstrb_o,
    input  logic            bus_rsp_valid_i,
    input  logic [XLEN-1:0] bus_rsp_rdata_i,
    input  logic            bus_rsp_err_i,
    output logic            mem_stall_o,
    output logic            mem_done_o,
    output logic [XLEN-1:0] mem_rdata_o,
    output logic            ld_misalign_o,
    output logic            ld_bus_err_o,
    output logic            st_misalign_o,
    output logic            st_bus_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t          state, state_nxt;
    logic            cap_load;
    logic [2:0]      cap_funct3;
    logic [XLEN-1:0] cap_addr;
    logic [XLEN-1:0] cap_wdata;

    logic            is_load, is_store, act;

    function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] a);
        case (f3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = a[0];
            2'b10:   misaligned = |a[1:0];
            default: misaligned = |a[2:0];
        endcase
    endfunction

    function automatic logic [7:0] strobe(input logic [2:0] f3, input logic [2:0] lane);
        logic [7:0] m;
        case (f3[1:0])
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        strobe = m << lane;
    endfunction

    function automatic logic [XLEN-1:0] extract(input logic [2:0] f3, input logic [2:0] lane,
                                                input logic [XLEN-1:0] d);
        logic [XLEN-1:0] sh;
        sh = d >> {lane, 3'b000};
        case (f3)
            3'b000:  extract = {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'b001:  extract = {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b010:  extract = {{(XLEN-32){sh[31]}}, sh[31:0]};
            3'b100:  extract = {{(XLEN-8){1'b0}}, sh[7:0]};
            3'b101:  extract = {{(XLEN-16){1'b0}}, sh[15:0]};
            3'b110:  extract = {{(XLEN-32){1'b0}}, sh[31:0]};
            default: extract = sh;
        endcase
    endfunction

    // load takes priority if both decode bits are set
    assign is_load  = mem_load_i;
    assign is_store = mem_store_i & ~mem_load_i;
    assign act      = mem_valid_i & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cap_load   <= 1'b0;
            cap_funct3 <= 3'b000;
            cap_addr   <= '0;
            cap_wdata  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && bus_req_valid_o) begin
                cap_load   <= is_load;
                cap_funct3 <= mem_funct3_i;
                cap_addr   <= mem_addr_i;
                cap_wdata  <= mem_wdata_i;
            end
        end
    end

    always_comb begin
        logic            req_we;
        logic [2:0]      req_f3;
        logic [XLEN-1:0] req_addr;
        logic [XLEN-1:0] req_wdata;

        state_nxt       = state;
        bus_req_valid_o = 1'b0;
        mem_stall_o     = 1'b0;
        mem_done_o      = 1'b0;
        mem_rdata_o     = '0;
        ld_misalign_o   = 1'b0;
        st_misalign_o   = 1'b0;
        ld_bus_err_o    = 1'b0;
        st_bus_err_o    = 1'b0;

        // in IDLE the request comes straight from EX/MEM, afterwards from the captured copy
        if (state == S_IDLE) begin
            req_we    = is_store;
            req_f3    = mem_funct3_i;
            req_addr  = mem_addr_i;
            req_wdata = mem_wdata_i;
        end else begin
            req_we    = ~cap_load;
            req_f3    = cap_funct3;
            req_addr  = cap_addr;
            req_wdata = cap_wdata;
        end

        case (state)
            S_IDLE: begin
                if (mem_valid_i && (is_load || is_store)) begin
                    if (misaligned(mem_funct3_i, mem_addr_i[2:0])) begin
                        mem_done_o    = act;
                        ld_misalign_o = act & is_load;
                        st_misalign_o = act & is_store;
                    end else if (!flush_i) begin
                        bus_req_valid_o = 1'b1;
                        mem_stall_o     = 1'b1;
                        state_nxt       = bus_req_ready_i ? S_WAIT : S_REQ;
                    end
                end else begin
                    mem_done_o = act;
                end
            end
            S_REQ: begin
                if (flush_i) begin
                    state_nxt = S_IDLE;
                end else begin
                    bus_req_valid_o = 1'b1;
                    mem_stall_o     = 1'b1;
                    if (bus_req_ready_i) state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    mem_stall_o = ~bus_rsp_valid_i;
                    state_nxt   = bus_rsp_valid_i ? S_IDLE : S_DRAIN;
                end else if (bus_rsp_valid_i) begin
                    mem_done_o   = mem_valid_i;
                    ld_bus_err_o = mem_valid_i & bus_rsp_err_i & cap_load;
                    st_bus_err_o = mem_valid_i & bus_rsp_err_i & ~cap_load;
                    if (cap_load && !bus_rsp_err_i)
                        mem_rdata_o = extract(cap_funct3, cap_addr[2:0], bus_rsp_rdata_i);
                    state_nxt = S_IDLE;
                end else begin
                    mem_stall_o = 1'b1;
                end
            end
            default: begin
                mem_stall_o = 1'b1;
                if (bus_rsp_valid_i) state_nxt = S_IDLE;
            end
        endcase

        if (rst) begin
            state_nxt       = S_IDLE;
            bus_req_valid_o = 1'b0;
            mem_stall_o     = 1'b0;
            mem_done_o      = 1'b0;
            mem_rdata_o     = '0;
            ld_misalign_o   = 1'b0;
            st_misalign_o   = 1'b0;
            ld_bus_err_o    = 1'b0;
            st_bus_err_o    = 1'b0;
        end

        bus_req_addr_o  = {req_addr[XLEN-1:3], 3'b000};
        bus_req_wdata_o = req_wdata << {req_addr[2:0], 3'b000};
        bus_req_we_o    = bus_req_valid_o & req_we;
        bus_req_wstrb_o = bus_req_valid_o ? strobe(req_f3, req_addr[2:0]) : 8'h00;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-access stage of the 5-stage pipeline, between the EX/MEM and MEM/WB pipeline registers. It runs load/store instructions on a single-outstanding valid/ready data bus and checks alignment. It extracts and sign/zero-extends load data. It raises the load/store misalign and bus-error flags that the write-back stage turns into traps. The pipeline is stalled while a bus transaction is in flight, and the stage drains safely when write-back flushes the pipeline.

## Interface
Parameters:
- XLEN, 64, data/address width; the data bus is XLEN wide.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  reset.
- mem_valid_i  in  1  EX/MEM holds a valid instruction.
- mem_load_i  in  1  instruction is a load.
- mem_store_i  in  1  instruction is a store.
- mem_funct3_i  in  3  access size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
- mem_addr_i  in  XLEN  effective address (ALU result).
- mem_wdata_i  in  XLEN  store data, right-aligned.
- flush_i  in  1  trap/flush from write-back.
- bus_req_valid_o  out  1  request valid.
- bus_req_ready_i  in  1  bus accepts request.
- bus_req_we_o  out  1  1 for store.
- bus_req_addr_o  out  XLEN  address, aligned down to 8 bytes.
- bus_req_wdata_o  out  XLEN  store data shifted to byte lane.
- bus_req_wstrb_o  out  8  byte strobes.
- bus_rsp_valid_i  in  1  response valid.
- bus_rsp_rdata_i  in  XLEN  read data, whole doubleword.
- bus_rsp_err_i  in  1  access fault.
- mem_stall_o  out  1  hold EX/MEM and earlier stages; insert a bubble into MEM/WB.
- mem_done_o  out  1  MEM/WB may capture this cycle.
- mem_rdata_o  out  XLEN  extended load result.
- ld_misalign_o, ld_bus_err_o, st_misalign_o, st_bus_err_o  out  1 each  exception flags.

## Operation
- Misalign checks:
  - h/hu: addr[0]≠0.
  - w/wu: addr[1:0]≠0.
  - d: addr[2:0]≠0.
- A misaligned access issues no bus request. It completes in the same cycle with the matching misalign flag and rdata=0.
- A non-memory valid instruction, or mem_valid_i=0, passes through: done=mem_valid_i, stall=0, flags 0.
- FSM has states IDLE, REQ, WAIT, DRAIN.
- IDLE:
  - An aligned load/store drives bus_req_valid_o combinationally.
  - On ready, go to WAIT. Otherwise go to REQ.
  - stall=1.
- REQ:
  - Hold bus_req_* stable from the captured copy of the EX/MEM inputs.
  - On ready, go to WAIT.
- WAIT:
  - stall=1 until bus_rsp_valid_i.
  - In the response cycle: done=1, stall=0, go to IDLE.
  - If err=1, assert ld_bus_err_o or st_bus_err_o and force rdata=0.
- Load extraction:
  - lane = addr[2:0].
  - byte = rdata[8*lane +: 8], half = rdata[8*lane +: 16], word = rdata[8*lane +: 32].
  - Sign-extend for b/h/w; zero-extend for bu/hu/wu; d is passed as-is.
- Store:
  - wdata = mem_wdata_i << 8*lane.
  - wstrb = (b:0x01, h:0x03, w:0x0F, d:0xFF) << lane.
  - Store data is not returned: rdata=0.
- flush_i:
  - In IDLE or REQ with the request not yet accepted: drop it and go to IDLE. A REQ-state request may be withdrawn only on flush.
  - In WAIT: go to DRAIN. The response, when it arrives, is discarded: no done, no flags. Then go to IDLE.
  - DRAIN: stall=1, no new request issued.
- All flags and done are gated by mem_valid_i and !flush_i.

## Timing
- Reset values:
  - state=IDLE.
  - bus_req_valid_o=0, bus_req_we_o=0, bus_req_wstrb_o=0.
  - mem_stall_o=0, mem_done_o=0, all flags 0, mem_rdata_o=0.
- Bus contract: rsp_valid arrives no earlier than the cycle after acceptance. At most one request is outstanding.
- Minimum aligned-access latency: accept in cycle 0, response and done in cycle 1. The pipeline stalls for 1 cycle.
- Misaligned and non-memory instructions: 0 extra cycles.
- Request held over N not-ready cycles: address/data/strobe stay stable. Total stall is N+1+response wait.
- Reset during WAIT or DRAIN: return to IDLE immediately. Any later stray response is ignored in IDLE.
- Simultaneous flush_i and bus_rsp_valid_i in WAIT: the response is discarded, no done, go to IDLE.

## Test plan
- lb at addr 0x1003, rsp rdata=0x00000000_80000000 → rdata_o=0xFFFFFFFF_FFFFFF80, done in cycle 1, stall high only in cycle 0.
- sh at addr 0x2006, wdata=0xABCD → bus wstrb=0xC0, wdata=0xABCD_0000_0000_0000, we=1; ready held low 3 cycles keeps outputs stable.
- lw at addr 0x3002 → ld_misalign_o=1, no bus_req_valid_o, done same cycle, stall=0.
- sd at 0x4000 with rsp err=1 → st_bus_err_o=1, done=1, ld_bus_err_o=0.
- lhu accepted, flush_i in WAIT, rsp arrives 2 cycles later with 0x1234 → no done, no flags, stall until rsp, then IDLE, next ld proceeds normally.
- rst asserted in WAIT → all outputs at reset values next cycle; a following rsp_valid pulse produces no done.
